// File: rtl/fcart_reg_pkg.sv
// Shared register-bridge types: SPI opcodes, register addresses, the pending-write slot
// and the bridge FSM state encoding.
package fcart_reg_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_RSVD  = 2'b11
  } spi_op_t;

  localparam logic [3:0] REG_MAPPER   = 4'd0;
  localparam logic [3:0] REG_LAUNCHER = 4'd1;

  typedef struct packed {
    logic        valid;
    logic [3:0]  addr;
    logic [12:0] value;
  } wr_slot_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_IGNORE,
    ST_DONE
  } bridge_state_t;

endpackage

// File: rtl/mcu_reg_bridge_if.sv
// SPI link between the MCU (master) and the register bridge (slave).
interface mcu_reg_bridge_if;
  logic spi_sck;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_sck, output spi_cs_n, output spi_mosi, input spi_miso);
  modport slave  (input spi_sck, input spi_cs_n, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_edge_sync.sv
// Brings the asynchronous SPI pins into the clk domain and derives single-cycle
// edge pulses for sck and cs_n.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sck,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_cs_fall,
  output logic o_cs_rise,
  output logic o_mosi
);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: cs_n resets to "asserted" so a frame already in progress when reset
      // releases never produces a fall pulse; only a genuine high->low edge does.
      r_sck_sync  <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its pre-edge neighbour.
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  assign o_sck_rise = r_sck_sync[SYNC_STAGES-1] & ~r_sck_d;
  assign o_sck_fall = ~r_sck_sync[SYNC_STAGES-1] & r_sck_d;
  assign o_cs_fall  = ~r_cs_sync[SYNC_STAGES-1] & r_cs_d;
  assign o_cs_rise  = r_cs_sync[SYNC_STAGES-1] & ~r_cs_d;
  assign o_mosi     = r_mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/mcu_reg_bridge.sv
// SPI slave decoding MCU register writes into a rate-limited, toggle-announced
// wr_reg/wr_reg_addr pair, and serving snapshotted status_reg reads.
module mcu_reg_bridge
  import fcart_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  mcu_reg_bridge_if.slave      spi,
  input  logic [31:0]          status_reg,
  output logic [12:0]          wr_reg,
  output logic [3:0]           wr_reg_addr,
  output logic                 wr_reg_changed,
  output logic                 overflow
);

  localparam int                   TIMER_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [TIMER_W-1:0]   HOLD_RELOAD = TIMER_W'(HOLD_CYCLES - 1);

  logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise, w_mosi;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .i_sck      (spi.spi_sck),
    .i_cs_n     (spi.spi_cs_n),
    .i_mosi     (spi.spi_mosi),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_cs_fall  (w_cs_fall),
    .o_cs_rise  (w_cs_rise),
    .o_mosi     (w_mosi)
  );

  bridge_state_t      r_state;
  logic [2:0]         r_bit_cnt;
  logic [1:0]         r_byte_cnt;
  logic [12:0]        r_shift_in;
  logic [3:0]         r_cmd_addr;
  logic [31:0]        r_rd_shift;
  logic               r_miso;
  logic [12:0]        w_shift_next;

  // Only the low 13 bits are kept: the payload's top three bits fall off the end.
  assign w_shift_next = {r_shift_in[11:0], w_mosi};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shift_in <= '0;
      r_cmd_addr <= '0;
      r_rd_shift <= '0;
      r_miso     <= 1'b0;
    end else if (w_cs_rise) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shift_in <= '0;
      r_rd_shift <= '0;
      r_miso     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_cs_fall) begin
          r_state    <= ST_CMD;
          r_bit_cnt  <= '0;
          r_byte_cnt <= '0;
          r_shift_in <= '0;
        end
        ST_CMD: if (w_sck_rise) begin
          r_shift_in <= w_shift_next;
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_cmd_addr <= w_shift_next[3:0];
            case (spi_op_t'(w_shift_next[7:6]))
              OP_WRITE: r_state <= ST_WR_DATA;
              OP_READ: begin
                r_state    <= ST_RD_DATA;
                r_rd_shift <= status_reg;
              end
              default:  r_state <= ST_IGNORE;
            endcase
          end
        end
        ST_WR_DATA: if (w_sck_rise) begin
          r_shift_in <= w_shift_next;
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd1) r_state <= ST_DONE;
          end
        end
        // Zeros shift in behind the snapshot, so bytes past the fourth read as 0.
        ST_RD_DATA: if (w_sck_fall) begin
          r_miso     <= r_rd_shift[31];
          r_rd_shift <= {r_rd_shift[30:0], 1'b0};
        end
        ST_DONE: r_state <= ST_IGNORE;
        default: ;
      endcase
    end
  end

  assign spi.spi_miso = r_miso;

  wr_slot_t           r_slot;
  logic [TIMER_W-1:0] r_timer;
  logic [12:0]        r_wr_reg;
  logic [3:0]         r_wr_addr;
  logic               r_toggle;
  logic               r_overflow;
  logic               w_commit;

  assign w_commit = r_slot.valid && (r_timer == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot     <= '0;
      r_timer    <= '0;
      r_wr_reg   <= '0;
      r_wr_addr  <= '0;
      r_toggle   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_commit) begin
        r_wr_reg  <= r_slot.value;
        r_wr_addr <= r_slot.addr;
        r_toggle  <= ~r_toggle;
        r_timer   <= HOLD_RELOAD;
      end else if (r_timer != '0) begin
        r_timer <= r_timer - TIMER_W'(1);
      end
      // A slot being committed this edge is free, so refilling it is not an overflow.
      if (r_state == ST_DONE) begin
        r_slot.valid <= 1'b1;
        r_slot.addr  <= r_cmd_addr;
        r_slot.value <= r_shift_in;
        if (r_slot.valid && !w_commit) r_overflow <= 1'b1;
      end else if (w_commit) begin
        r_slot.valid <= 1'b0;
      end
    end
  end

  assign wr_reg         = r_wr_reg;
  assign wr_reg_addr    = r_wr_addr;
  assign wr_reg_changed = r_toggle;
  assign overflow       = r_overflow;

endmodule
